// File: rtl/capseq_pkg.sv
// -----------------------------------------------------------------------------
// capseq_pkg
// Shared types and constants for the capture sequencer.
//   capseq_state_e : 3-bit FSM state encoding (also the state_o readback value)
//   capseq_err_e   : 2-bit error code encoding
//   ERR_CODE_*     : err_code values, shared with the FSMC status register decode
// -----------------------------------------------------------------------------
package capseq_pkg;

  localparam logic [1:0] ERR_CODE_NONE      = 2'd0;
  localparam logic [1:0] ERR_CODE_TIMEOUT   = 2'd1;
  localparam logic [1:0] ERR_CODE_LOCK_LOST = 2'd2;
  localparam logic [1:0] ERR_CODE_ABORTED   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FREQ = 3'd1,
    ST_WAIT_GAIN = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } capseq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = ERR_CODE_NONE,
    ERR_TIMEOUT   = ERR_CODE_TIMEOUT,
    ERR_LOCK_LOST = ERR_CODE_LOCK_LOST,
    ERR_ABORTED   = ERR_CODE_ABORTED
  } capseq_err_e;

endpackage

// File: rtl/capseq_timer.sv
// -----------------------------------------------------------------------------
// capseq_timer
// Loadable down-counter with a zero flag. Counting stops at zero.
// Ports:
//   clk      : core clock
//   rst      : synchronous reset, active high (count -> 0)
//   load     : load load_val (has priority over en)
//   en       : decrement by one while non-zero
//   load_val : value loaded on load
//   zero     : count is zero
// -----------------------------------------------------------------------------
module capseq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
// Measurement scheduler for the distortion-analysis path. After a start
// command it waits for frequency lock, then gain lock, then a settle interval
// with both locks held, then stores one DEPTH-sample capture into the buffer.
//
// Optional feature: define CAPSEQ_RETRY_EN to restart the sequence (up to
// MAX_RETRY times) on lock loss during capture instead of failing at once.
//
// Ports:
//   clk, rst     : 200 MHz core clock, synchronous active-high reset
//   start, abort : 1-cycle MCU command pulses
//   freq_stable  : frequency loop locked (level)
//   gain_stable  : gain loop locked (level)
//   sample_stb   : 1-cycle pulse per synchronised ADC sample
//   buf_we       : buffer write enable, one cycle per stored sample
//   buf_addr     : buffer write address (valid with buf_we)
//   busy         : sequence in progress (not IDLE/DONE/ERROR)
//   done, err    : sticky completion / failure flags
//   err_code     : 0 none, 1 timeout, 2 lock lost, 3 aborted
//   state_o      : current FSM state for status readback
// -----------------------------------------------------------------------------
module capture_sequencer
  import capseq_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 10,
  parameter int SETTLE_CYCLES  = 200_000,
  parameter int TIMEOUT_CYCLES = 20_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              freq_stable,
  input  logic              gain_stable,
  input  logic              sample_stb,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        state_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  // Timers are loaded with N-1 and the FSM acts on the zero flag, so the
  // transition lands exactly N clocks after the load edge.
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if ((DEPTH != (1 << ADDR_W)) || (SETTLE_CYCLES < 1) ||
      (TIMEOUT_CYCLES < 1) || (MAX_RETRY < 0)) begin : g_cfg_check
    $error("capture_sequencer: inconsistent parameters");
  end

  capseq_state_e     state;
  logic [ADDR_W-1:0] wr_ptr;      // address the next sample will be written to

  logic locked;
  logic wait_st;
  logic busy_st;
  logic go;
  logic last_wr_done;
  logic cap_loss;
  logic retry_go;
  logic tmo_load;
  logic tmo_zero;
  logic settle_load;
  logic settle_en;
  logic settle_zero;

  assign locked  = freq_stable & gain_stable;
  assign wait_st = (state == ST_WAIT_FREQ) || (state == ST_WAIT_GAIN) ||
                   (state == ST_SETTLE);
  assign busy_st = wait_st || (state == ST_CAPTURE);

  // Abort beats start; in a non-busy state that means nothing happens.
  assign go = !busy_st && start && !abort;

  // The final write is on buf_we this cycle; completion is taken before any
  // lock check so a loss after the last sample cannot spoil a full capture.
  assign last_wr_done = (state == ST_CAPTURE) && buf_we && (buf_addr == LAST_ADDR);
  assign cap_loss     = (state == ST_CAPTURE) && !abort && !last_wr_done && !locked;

`ifdef CAPSEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_cnt;

  assign retry_go = cap_loss && (retry_cnt != RETRY_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (go) begin
      retry_cnt <= '0;
    end else if (retry_go) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_go = 1'b0;
`endif

  assign tmo_load    = go || retry_go;
  assign settle_load = (state == ST_WAIT_GAIN) && locked;
  assign settle_en   = (state == ST_SETTLE) && locked;

  capseq_timer #(.W(TMO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .en       (wait_st),
    .load_val (TMO_LOAD),
    .zero     (tmo_zero)
  );

  capseq_timer #(.W(SET_W)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .en       (settle_en),
    .load_val (SET_LOAD),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      wr_ptr   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_CODE_NONE;
    end else begin
      buf_we <= 1'b0;
      if (busy_st && abort) begin
        state    <= ST_ERROR;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= ERR_CODE_ABORTED;
      end else if (wait_st && tmo_zero) begin
        state    <= ST_ERROR;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= ERR_CODE_TIMEOUT;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (go) begin
              state    <= ST_WAIT_FREQ;
              busy     <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
              err_code <= ERR_CODE_NONE;
              buf_addr <= '0;
              wr_ptr   <= '0;
            end
          end
          ST_WAIT_FREQ: begin
            if (freq_stable) state <= ST_WAIT_GAIN;
          end
          ST_WAIT_GAIN: begin
            if (!freq_stable)     state <= ST_WAIT_FREQ;
            else if (gain_stable) state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (!locked)          state <= ST_WAIT_FREQ;
            else if (settle_zero) state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (last_wr_done) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              buf_addr <= '0;
            end else if (!locked) begin
              // A sample arriving with the loss is dropped.
              if (retry_go) begin
                state    <= ST_WAIT_FREQ;
                buf_addr <= '0;
                wr_ptr   <= '0;
              end else begin
                state    <= ST_ERROR;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_CODE_LOCK_LOST;
              end
            end else begin
              // buf_addr shows the write address during buf_we, then the
              // next free address once the strobe has passed.
              buf_addr <= wr_ptr;
              if (sample_stb) begin
                buf_we <= 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;
  import capseq_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              freq_stable = 1'b0;
  logic              gain_stable = 1'b0;
  logic              sample_stb = 1'b0;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [2:0]        state_o;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  capture_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(8),
    .TIMEOUT_CYCLES(100), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .freq_stable(freq_stable), .gain_stable(gain_stable),
    .sample_stb(sample_stb), .buf_we(buf_we), .buf_addr(buf_addr),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .state_o(state_o)
  );

  always #2.5 clk = ~clk;

  // Write monitor: every buf_we must match the next queued address.
  always @(negedge clk) begin
    if (buf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got write at addr %0d, required no write", buf_addr);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(buf_addr) != e) begin
          errors++;
          $display("FAIL write_addr: got %0d required %0d", buf_addr, e);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One strobe then three idle cycles; queue the address if a write is due.
  task automatic sample(input int addr);
    exp_q.push_back(addr);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    tick(3);
  endtask

  task automatic wait_state(input int target, input int budget, output int n);
    n = 0;
    while (int'(state_o) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(state_o) != target) n = -1;
  endtask

  // Fill addresses 0..6 then lose lock coincident with a strobe.
  task automatic capture_then_loss();
    for (int a = 0; a < 7; a++) sample(a);
    chk("addr_before_loss", int'(buf_addr), 7);
    freq_stable = 1'b0;
    sample_stb  = 1'b1;
    tick();
    sample_stb  = 1'b0;
    freq_stable = 1'b1;
  endtask

  initial begin
    int n;
    tick(3);
    chk("rst_state", int'(state_o), int'(ST_IDLE));
    chk("rst_buf_we", int'(buf_we), 0);
    chk("rst_buf_addr", int'(buf_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err) * 4 + int'(err_code), 0);
    rst = 1'b0;
    tick();

    // Nominal run.
    freq_stable = 1'b1;
    gain_stable = 1'b1;
    do_start();
    chk("nom_wait_freq", int'(state_o), int'(ST_WAIT_FREQ));
    chk("nom_busy", int'(busy), 1);
    wait_state(int'(ST_SETTLE), 20, n);
    chk("nom_to_settle", n, 2);
    wait_state(int'(ST_CAPTURE), 20, n);
    chk("nom_settle_len", n, 8);
    for (int a = 0; a < DEPTH; a++) sample(a);
    chk("nom_state_done", int'(state_o), int'(ST_DONE));
    chk("nom_done", int'(done), 1);
    chk("nom_busy_low", int'(busy), 0);
    chk("nom_addr_wrap", int'(buf_addr), 0);
    chk("nom_no_err", int'(err), 0);

    // Lock loss during settle, then abort+start at addr 5.
    do_start();
    chk("restart_done_clr", int'(done), 0);
    wait_state(int'(ST_SETTLE), 20, n);
    chk("sl_to_settle", n, 2);
    tick(3);
    gain_stable = 1'b0;
    tick();
    chk("sl_back_wait_freq", int'(state_o), int'(ST_WAIT_FREQ));
    gain_stable = 1'b1;
    wait_state(int'(ST_SETTLE), 20, n);
    chk("sl_resettle", n, 2);
    wait_state(int'(ST_CAPTURE), 20, n);
    chk("sl_full_settle", n, 8);
    for (int a = 0; a < 5; a++) sample(a);
    chk("ab_addr", int'(buf_addr), 5);
    abort = 1'b1;
    start = 1'b1;
    sample_stb = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    sample_stb = 1'b0;
    chk("ab_state", int'(state_o), int'(ST_ERROR));
    chk("ab_code", int'(err_code), 3);
    chk("ab_busy", int'(busy), 0);
    tick(2);
    chk("ab_stays_error", int'(state_o), int'(ST_ERROR));

    // Timeout, with strobes held outside capture.
    freq_stable = 1'b0;
    do_start();
    chk("to_err_clr", int'(err), 0);
    sample_stb = 1'b1;
    wait_state(int'(ST_ERROR), 150, n);
    sample_stb = 1'b0;
    chk("to_latency", n, 100);
    chk("to_code", int'(err_code), 1);
    chk("to_busy", int'(busy), 0);
    chk("to_err", int'(err), 1);

    // Lock loss during capture.
    freq_stable = 1'b1;
    do_start();
    wait_state(int'(ST_CAPTURE), 30, n);
    chk("ll_to_capture", n, 10);
`ifdef CAPSEQ_RETRY_EN
    for (int k = 0; k < 2; k++) begin
      capture_then_loss();
      chk("ll_retry_state", int'(state_o), int'(ST_WAIT_FREQ));
      chk("ll_retry_addr", int'(buf_addr), 0);
      chk("ll_retry_busy", int'(busy), 1);
      wait_state(int'(ST_CAPTURE), 30, n);
      chk("ll_retry_recapture", n, 10);
    end
`endif
    capture_then_loss();
    chk("ll_state", int'(state_o), int'(ST_ERROR));
    chk("ll_code", int'(err_code), 2);
    chk("ll_busy", int'(busy), 0);

    // Reset mid-capture.
    do_start();
    wait_state(int'(ST_CAPTURE), 30, n);
    chk("rm_to_capture", n, 10);
    for (int a = 0; a < 3; a++) sample(a);
    rst = 1'b1;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    chk("rm_state", int'(state_o), int'(ST_IDLE));
    chk("rm_addr", int'(buf_addr), 0);
    chk("rm_flags", int'(busy) + int'(done) + int'(err) + int'(err_code), 0);
    rst = 1'b0;
    tick(2);

    chk("pending_writes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
